// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle (AW, W, B, AR, R) shared by a master and the SRAM slave.
interface axi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a word-addressed SRAM array, with independent
// read and write burst engines so both directions can be in flight at once.
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 1024
) (
    input  logic clk,
    input  logic rst,
    axi_if.slave axi
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  live_q;

    wstate_t               w_state_q, w_state_d;
    logic [IDX_W-1:0]      w_idx_q,   w_idx_d;
    logic [7:0]            w_cnt_q,   w_cnt_d;
    logic [7:0]            w_len_q,   w_len_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic                  w_err_q,   w_err_d;
    logic                  w_past_q,  w_past_d;
    logic                  mem_we;

    rstate_t               r_state_q, r_state_d;
    logic [IDX_W-1:0]      r_idx_q,   r_idx_d;
    logic [7:0]            r_cnt_q,   r_cnt_d;
    logic [7:0]            r_len_q,   r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;

    // Size and upper/lower address bits carry no meaning for this memory.
    logic unused_bits;
    assign unused_bits = ^{axi.awsize, axi.arsize, axi.awaddr, axi.araddr};

    // Hold both address channels closed until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) live_q <= 1'b0;
        else     live_q <= 1'b1;
    end

    // Write-side state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            w_past_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            w_past_q  <= w_past_d;
        end
    end

    // Write-side next state: capture AW, absorb beats until WLAST, then respond.
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        w_past_d  = w_past_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (axi.awvalid && live_q) begin
                    w_idx_d   = axi.awaddr[OFF_W+IDX_W-1:OFF_W];
                    w_len_d   = axi.awlen;
                    w_burst_d = axi.awburst;
                    w_cnt_d   = '0;
                    w_err_d   = axi.awburst[1];
                    w_past_d  = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi.wvalid) begin
                    // Unsupported bursts and beats beyond AWLEN are swallowed.
                    mem_we  = !w_burst_q[1] && !w_past_q;
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (w_burst_q != BURST_FIXED) w_idx_d = w_idx_q + 1'b1;
                    if (!w_past_q && (w_cnt_q == w_len_q) && !axi.wlast) begin
                        w_err_d  = 1'b1;
                        w_past_d = 1'b1;
                    end
                    if (axi.wlast) begin
                        if (w_past_q || (w_cnt_q != w_len_q)) w_err_d = 1'b1;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign axi.awready = (w_state_q == W_IDLE) && live_q;
    assign axi.wready  = (w_state_q == W_DATA);
    assign axi.bvalid  = (w_state_q == W_RESP);
    assign axi.bresp   = ((w_state_q == W_RESP) && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < BYTES; k++) begin
                if (axi.wstrb[k]) mem[w_idx_q][k*8 +: 8] <= axi.wdata[k*8 +: 8];
            end
        end
    end

    // Read-side state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
        end
    end

    // Read-side next state: capture AR, then stream ARLEN+1 beats.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi.arvalid && live_q) begin
                    r_idx_d   = axi.araddr[OFF_W+IDX_W-1:OFF_W];
                    r_len_d   = axi.arlen;
                    r_burst_d = axi.arburst;
                    r_cnt_d   = '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.rready) begin
                    r_cnt_d = r_cnt_q + 8'd1;
                    if (r_burst_q != BURST_FIXED) r_idx_d = r_idx_q + 1'b1;
                    if (r_cnt_q == r_len_q) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Data comes straight off the index register, so a stalled beat sees
    // a same-word write one cycle after it lands.
    assign axi.arready = (r_state_q == R_IDLE) && live_q;
    assign axi.rvalid  = (r_state_q == R_DATA);
    assign axi.rlast   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
    assign axi.rresp   = ((r_state_q == R_DATA) && r_burst_q[1]) ? RESP_SLVERR : RESP_OKAY;
    assign axi.rdata   = ((r_state_q == R_DATA) && !r_burst_q[1]) ? mem[r_idx_q] : '0;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised and directed bench for axi_sram_slave against a word-array reference.
module tb_axi_sram_slave;
    localparam int AW    = 32;
    localparam int DW    = 128;
    localparam int DEPTH = 1024;
    localparam int BYTES = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .axi (axi.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]    mm    [DEPTH];
    bit               known [DEPTH];
    logic [DW-1:0]    wd    [256];
    logic [BYTES-1:0] ws    [256];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr / BYTES) % DEPTH);
    endfunction

    // Reference: apply beats 0..len (never more), return the expected BRESP.
    function automatic logic [1:0] model_wr(input logic [31:0] addr, input int len,
                                            input logic [1:0] burst, input int nb);
        int b;
        int ix;
        b = widx(addr);
        if (burst > 2'd1) return 2'b10;
        for (int i = 0; i < nb && i <= len; i++) begin
            ix = (burst == 2'd0) ? b : (b + i) % DEPTH;
            for (int k = 0; k < BYTES; k++)
                if (ws[i][k]) mm[ix][k*8 +: 8] = wd[i][k*8 +: 8];
            if (ws[i] == '1) known[ix] = 1'b1;
        end
        return (nb != len + 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic fill_rand(input int nb, input bit rnd_strb);
        for (int i = 0; i < nb; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            ws[i] = rnd_strb ? BYTES'($urandom) : '1;
        end
    endtask

    task automatic axi_wr(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int nb, input int bdly, input string tag);
        logic [1:0] exp;
        int n;
        exp = model_wr(addr, len, burst, nb);
        axi.awaddr  = addr;
        axi.awlen   = 8'(len);
        axi.awsize  = 3'd4;
        axi.awburst = burst;
        axi.awvalid = 1'b1;
        n = 0;
        while (!axi.awready && n < 50) begin @(posedge clk); #1; n++; end
        if (!axi.awready) begin
            chk({tag, "_aw_timeout"}, DW'(0), DW'(1));
            axi.awvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            axi.wvalid = 1'b1;
            axi.wdata  = wd[i];
            axi.wstrb  = ws[i];
            axi.wlast  = (i == nb - 1);
            n = 0;
            while (!axi.wready && n < 50) begin @(posedge clk); #1; n++; end
            if (!axi.wready) begin
                chk({tag, "_w_timeout"}, DW'(0), DW'(1));
                axi.wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        chk({tag, "_bvalid_next"}, DW'(axi.bvalid), DW'(1));
        for (int d = 0; d < bdly; d++) begin
            chk({tag, "_bvalid_hold"}, DW'(axi.bvalid), DW'(1));
            chk({tag, "_awready_blocked"}, DW'(axi.awready), DW'(0));
            @(posedge clk); #1;
        end
        chk({tag, "_bresp"}, DW'(axi.bresp), DW'(exp));
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        chk({tag, "_bvalid_clear"}, DW'(axi.bvalid), DW'(0));
        chk({tag, "_awready_back"}, DW'(axi.awready), DW'(1));
    endtask

    // mode 0: RREADY always high; 1: pattern 1,0,0 repeating; 2: random.
    task automatic axi_rd(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int mode, input string tag);
        int b;
        int ix;
        int beat;
        int cyc;
        int n;
        logic ok;
        logic rr;
        logic [DW-1:0] hd;
        logic hl;
        logic [1:0] hr;
        b  = widx(addr);
        ok = (burst < 2'd2);
        axi.araddr  = addr;
        axi.arlen   = 8'(len);
        axi.arsize  = 3'd4;
        axi.arburst = burst;
        axi.arvalid = 1'b1;
        n = 0;
        while (!axi.arready && n < 50) begin @(posedge clk); #1; n++; end
        if (!axi.arready) begin
            chk({tag, "_ar_timeout"}, DW'(0), DW'(1));
            axi.arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        chk({tag, "_rvalid_n1"}, DW'(axi.rvalid), DW'(1));
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 4000) begin
            if (!axi.rvalid) begin
                chk({tag, "_rvalid_lost"}, DW'(0), DW'(1));
                break;
            end
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 3 == 0);
                default: rr = 1'($urandom);
            endcase
            axi.rready = rr;
            hd = axi.rdata;
            hl = axi.rlast;
            hr = axi.rresp;
            if (rr) begin
                ix = (burst == 2'd0) ? b : (b + beat) % DEPTH;
                if (!ok)            chk({tag, "_rdata"}, axi.rdata, '0);
                else if (known[ix]) chk({tag, "_rdata"}, axi.rdata, mm[ix]);
                chk({tag, "_rresp"}, DW'(axi.rresp), ok ? DW'(0) : DW'(2));
                chk({tag, "_rlast"}, DW'(axi.rlast), DW'(beat == len));
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
            if (!rr) begin
                chk({tag, "_stall_rdata"}, axi.rdata, hd);
                chk({tag, "_stall_rlast"}, DW'(axi.rlast), DW'(hl));
                chk({tag, "_stall_rresp"}, DW'(axi.rresp), DW'(hr));
            end
        end
        axi.rready = 1'b0;
        chk({tag, "_beats"}, DW'(beat), DW'(len + 1));
        chk({tag, "_rvalid_end"}, DW'(axi.rvalid), DW'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  dummy;
        logic [1:0]  bsel;
        logic [31:0] a;
        int len;
        int nb;
        int r;

        axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wdata  = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b0;
        axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        #1 rst = 1'b1;
        #2;
        chk("rst_awready", DW'(axi.awready), DW'(0));
        chk("rst_arready", DW'(axi.arready), DW'(0));
        chk("rst_bvalid",  DW'(axi.bvalid),  DW'(0));
        chk("rst_rvalid",  DW'(axi.rvalid),  DW'(0));
        chk("rst_rdata",   axi.rdata, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_awready_low", DW'(axi.awready), DW'(0));
        @(posedge clk); #1;
        chk("rel_awready", DW'(axi.awready), DW'(1));
        chk("rel_arready", DW'(axi.arready), DW'(1));

        // Preload regions used below.
        fill_rand(32, 1'b0); axi_wr(32'h0, 31, 2'b01, 32, 0, "pre0");
        fill_rand(4, 1'b0);  axi_wr(32'(40 * BYTES), 3, 2'b01, 4, 0, "pre40");
        fill_rand(4, 1'b0);  axi_wr(32'(1020 * BYTES), 3, 2'b01, 4, 0, "pre1020");
        axi_rd(32'h0, 31, 2'b01, 0, "pre0_rd");

        // Basic INCR burst at 0x100.
        for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); ws[i] = '1; end
        axi_wr(32'h100, 3, 2'b01, 4, 0, "basic");
        axi_rd(32'h100, 3, 2'b01, 0, "basic_rd");

        // Partial strobe on word 0.
        wd[0] = '1; ws[0] = '1;     axi_wr(32'h0, 0, 2'b01, 1, 0, "ff");
        wd[0] = '0; ws[0] = 16'h000F; axi_wr(32'h0, 0, 2'b01, 1, 0, "strb");
        axi_rd(32'h0, 0, 2'b01, 0, "strb_rd");

        // Backpressure.
        fill_rand(8, 1'b0); axi_wr(32'h200, 7, 2'b01, 8, 5, "bp_wr");
        axi_rd(32'h200, 7, 2'b01, 1, "bp_rd");

        // Error cases.
        fill_rand(2, 1'b0); axi_wr(32'h100, 1, 2'b10, 2, 0, "wrap_wr");
        axi_rd(32'h100, 1, 2'b01, 0, "wrap_chk");
        fill_rand(2, 1'b0); axi_wr(32'h60, 3, 2'b01, 2, 0, "short");
        fill_rand(3, 1'b0); axi_wr(32'h80, 1, 2'b01, 3, 0, "long");
        axi_rd(32'h60, 5, 2'b01, 0, "len_chk");
        axi_rd(32'h100, 1, 2'b11, 0, "rsv_rd");

        // Index wrap at the top of memory, and FIXED.
        fill_rand(2, 1'b0); axi_wr(32'((DEPTH - 1) * BYTES), 1, 2'b01, 2, 0, "top");
        axi_rd(32'((DEPTH - 1) * BYTES), 1, 2'b01, 0, "top_rd");
        axi_rd(32'h0, 0, 2'b01, 0, "top_rd0");
        fill_rand(3, 1'b0); axi_wr(32'h50, 2, 2'b00, 3, 0, "fixed");
        axi_rd(32'h50, 0, 2'b01, 0, "fixed_rd");

        // Concurrent read and write bursts on disjoint words.
        fill_rand(4, 1'b0);
        fork
            axi_wr(32'(20 * BYTES), 3, 2'b01, 4, 1, "par_wr");
            axi_rd(32'(2 * BYTES), 3, 2'b01, 2, "par_rd");
        join
        axi_rd(32'(20 * BYTES), 3, 2'b01, 0, "par_chk");

        // Randomised traffic, including aliased upper address bits.
        for (int t = 0; t < 20; t++) begin
            r = $urandom_range(0, 5);
            bsel = (r == 0) ? 2'b00 : (r == 4) ? 2'b10 : (r == 5) ? 2'b11 : 2'b01;
            len  = $urandom_range(0, 7);
            r    = $urandom_range(0, 4);
            nb   = (r == 0) ? len + 2 : (r == 1 && len > 0) ? len : len + 1;
            a    = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 4) | ($urandom & 32'hF);
            fill_rand(nb, 1'($urandom));
            axi_wr(a, len, bsel, nb, $urandom_range(0, 3), "rnd_wr");
            axi_rd(a, len, (bsel == 2'b00) ? 2'b00 : 2'b01, 2, "rnd_rd");
        end

        // Reset in the middle of a write burst.
        fill_rand(4, 1'b0); axi_wr(32'(40 * BYTES), 3, 2'b01, 4, 0, "pre40b");
        fill_rand(2, 1'b0);
        axi.awaddr = 32'(40 * BYTES); axi.awlen = 8'd3; axi.awburst = 2'b01; axi.awvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.wvalid = 1'b1; axi.wdata = wd[i]; axi.wstrb = ws[i]; axi.wlast = 1'b0;
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0;
        dummy = model_wr(32'(40 * BYTES), 1, 2'b01, 2);
        rst = 1'b1;
        #1;
        chk("mid_awready", DW'(axi.awready), DW'(0));
        chk("mid_wready",  DW'(axi.wready),  DW'(0));
        chk("mid_bvalid",  DW'(axi.bvalid),  DW'(0));
        chk("mid_arready", DW'(axi.arready), DW'(0));
        chk("mid_rvalid",  DW'(axi.rvalid),  DW'(0));
        chk("mid_rlast",   DW'(axi.rlast),   DW'(0));
        chk("mid_bresp",   DW'(axi.bresp),   DW'(0));
        chk("mid_rresp",   DW'(axi.rresp),   DW'(0));
        chk("mid_rdata",   axi.rdata, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rel_awready_low", DW'(axi.awready), DW'(0));
        @(posedge clk); #1;
        chk("mid_rel_awready", DW'(axi.awready), DW'(1));
        chk("mid_rel_bvalid",  DW'(axi.bvalid),  DW'(0));
        chk("mid_rel_wready",  DW'(axi.wready),  DW'(0));
        axi_rd(32'(40 * BYTES), 3, 2'b01, 0, "mid_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
